// File: rtl/boot_loader.sv
// boot_loader: clears VRAM, copies the boot ROM image into RAM, then releases the CPU from reset.
module boot_loader #(
    parameter logic [12:0] LOAD_BASE  = 13'h0000,
    parameter int          VRAM_WORDS = 1024,
    parameter logic [7:0]  CLEAR_BYTE = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [12:0] prog_len,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [12:0] ada,
    output logic [7:0]  din,
    output logic        cea,
    output logic [9:0]  v_ada,
    output logic [7:0]  v_din,
    output logic        v_cea,
    output logic        busy,
    output logic        done,
    output logic        cpu_rst_n
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLEAR    = 3'd1;
    localparam logic [2:0] PREFETCH = 3'd2;
    localparam logic [2:0] COPY     = 3'd3;
    localparam logic [2:0] FINISH   = 3'd4;
    // Bytes left between LOAD_BASE and the top of the 8 KiB RAM space.
    localparam logic [13:0] ROOM  = 14'd8192 - {1'b0, LOAD_BASE};
    localparam logic [12:0] VLAST = 13'(VRAM_WORDS - 1);

    logic [2:0]  state;
    logic [12:0] cnt;
    logic [12:0] len;
    logic [12:0] eff_len;
    logic        released;
    logic        accept;
    logic        in_copy;
    logic        last_byte;

    assign accept    = state == IDLE && start;
    assign eff_len   = ({1'b0, prog_len} > ROOM) ? ROOM[12:0] : prog_len;
    assign in_copy   = state == COPY;
    assign last_byte = cnt == len - 13'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            len      <= '0;
            released <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= CLEAR;
                    cnt      <= '0;
                    len      <= eff_len;
                    released <= 1'b0;
                end
                CLEAR: begin
                    cnt <= (cnt == VLAST) ? 13'd0 : cnt + 13'd1;
                    if (cnt == VLAST) state <= (len == 13'd0) ? FINISH : PREFETCH;
                end
                PREFETCH: state <= COPY;
                COPY: begin
                    cnt <= cnt + 13'd1;
                    if (last_byte) state <= FINISH;
                end
                FINISH: begin
                    state    <= IDLE;
                    released <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ROM is read one byte ahead of the RAM write; the lookahead stops at the last byte.
    assign rom_addr  = in_copy ? (last_byte ? cnt : cnt + 13'd1) : 13'd0;
    assign cea       = in_copy;
    assign ada       = in_copy ? LOAD_BASE + cnt : 13'd0;
    assign din       = in_copy ? rom_data : 8'd0;
    assign v_cea     = state == CLEAR;
    assign v_ada     = v_cea ? cnt[9:0] : 10'd0;
    assign v_din     = v_cea ? CLEAR_BYTE : 8'd0;
    assign busy      = rst_n && (state == CLEAR || state == PREFETCH || in_copy || accept);
    assign done      = state == FINISH;
    assign cpu_rst_n = released || done;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven and randomized sequences checked against a spec-level model.
module tb_boot_loader;
    typedef struct {
        bit          s;
        logic [12:0] len;
        bit          rep;
        bit          abort;
        int          lat;
        int          nw;
    } vec_t;

    logic        clk = 0, rst_n = 0, start = 0, sel = 0;
    logic [12:0] plen = 0;
    logic [7:0]  rom [8192];
    logic [7:0]  rd0, rd1;
    logic [12:0] ra0, ra1, ada0, ada1;
    logic [7:0]  din0, din1, vd0, vd1;
    logic [9:0]  va0, va1;
    logic        cea0, cea1, vc0, vc1, b0, b1, d0, d1, c0, c1;
    logic [12:0] m_ra, m_ada;
    logic [7:0]  m_din, m_vdin;
    logic [9:0]  m_vada;
    logic        m_cea, m_vcea, m_busy, m_done, m_cpu;
    int          vec = 0, bad = 0;
    vec_t        tbl [9];

    always #5 clk = ~clk;
    always_ff @(posedge clk) begin
        rd0 <= rom[ra0];
        rd1 <= rom[ra1];
    end

    boot_loader u0 (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .prog_len(plen),
        .rom_addr(ra0), .rom_data(rd0), .ada(ada0), .din(din0), .cea(cea0),
        .v_ada(va0), .v_din(vd0), .v_cea(vc0), .busy(b0), .done(d0), .cpu_rst_n(c0)
    );
    boot_loader #(.LOAD_BASE(13'h1FFE), .VRAM_WORDS(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .prog_len(plen),
        .rom_addr(ra1), .rom_data(rd1), .ada(ada1), .din(din1), .cea(cea1),
        .v_ada(va1), .v_din(vd1), .v_cea(vc1), .busy(b1), .done(d1), .cpu_rst_n(c1)
    );

    assign m_ra   = sel ? ra1  : ra0;
    assign m_ada  = sel ? ada1 : ada0;
    assign m_din  = sel ? din1 : din0;
    assign m_cea  = sel ? cea1 : cea0;
    assign m_vada = sel ? va1  : va0;
    assign m_vdin = sel ? vd1  : vd0;
    assign m_vcea = sel ? vc1  : vc0;
    assign m_busy = sel ? b1   : b0;
    assign m_done = sel ? d1   : d0;
    assign m_cpu  = sel ? c1   : c0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] all_outs();
        return {m_busy, m_done, m_cea, m_vcea, m_cpu, m_ra, m_ada, m_din, m_vada, m_vdin};
    endfunction

    task automatic run(input bit s, input logic [12:0] len, input bit rep, input bit abort,
                       input int lat, input int nw);
        int n = 0, vi = 0, ri = 0, vw;
        bit fin = 0;
        logic [12:0] base;
        base = s ? 13'h1FFE : 13'h0000;
        vw   = s ? 8 : 1024;
        sel  = s;
        plen = len;
        @(posedge clk);
        #1 start = 1;
        while (!fin) begin
            @(negedge clk);
            if (n == 0) chk("busy_on_start", m_busy, 1);
            chk("strobe_excl", m_cea & m_vcea, 0);
            chk("ram_quiet", m_cea ? 0 : {m_ada, m_din}, 0);
            chk("vram_quiet", m_vcea ? 0 : {m_vada, m_vdin}, 0);
            if (m_busy && nw > 0) chk("rom_bound", m_ra > 13'(nw - 1), 0);
            if (m_vcea) begin
                chk("v_ada", m_vada, vi);
                chk("v_din", m_vdin, 8'h20);
                vi++;
            end
            if (m_cea) begin
                if (abort && ri == 2) begin
                    rst_n = 0;
                    fin = 1;
                end else begin
                    chk("ada", m_ada, base + 13'(ri));
                    chk("din", m_din, rom[ri]);
                    ri++;
                end
            end
            if (!fin && m_done) begin
                chk("latency", n, lat);
                chk("busy_at_done", m_busy, 0);
                chk("cpu_rel", m_cpu, 1);
                chk("vram_count", vi, vw);
                chk("ram_count", ri, nw);
                fin = 1;
            end else if (!fin && n > 0) chk("cpu_held", m_cpu, 0);
            if (!fin && n > lat + 5) begin
                chk("timeout", n, lat);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk);
                #1 n++;
                start = rep && (n == 10 || n == 500);
            end
        end
        start = 0;
        if (abort) begin
            #1 chk("abort_outs", all_outs(), 0);
            @(posedge clk);
            #1 rst_n = 1;
            repeat (20) begin
                @(negedge clk);
                chk("post_abort", {m_cea, m_vcea, m_busy, m_cpu}, 0);
            end
        end else begin
            @(negedge clk);
            chk("idle_after", {m_done, m_busy, m_cpu}, 3'b001);
        end
    endtask

    initial begin
        int len, eff, base;
        tbl[0] = '{0, 13'd4,    0, 0, 1030, 4};
        tbl[1] = '{0, 13'd0,    0, 0, 1025, 0};
        tbl[2] = '{1, 13'd5,    0, 0, 12,   2};
        tbl[3] = '{0, 13'd4,    1, 0, 1030, 4};
        tbl[4] = '{0, 13'd4,    0, 1, 1030, 4};
        tbl[5] = '{0, 13'd4,    0, 0, 1030, 4};
        tbl[6] = '{1, 13'd1,    0, 0, 11,   1};
        tbl[7] = '{1, 13'd8191, 0, 0, 12,   2};
        tbl[8] = '{1, 13'd0,    0, 0, 9,    0};
        for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
        rom[0] = 8'hA9; rom[1] = 8'h01; rom[2] = 8'h8D; rom[3] = 8'h00;
        repeat (2) @(negedge clk);
        sel = 0;
        #1 chk("reset_outs0", all_outs(), 0);
        sel = 1;
        #1 chk("reset_outs1", all_outs(), 0);
        @(posedge clk);
        #1 rst_n = 1;
        sel = 0;
        @(negedge clk);
        chk("idle_cpu_held", {m_cpu, m_busy}, 0);
        for (int i = 0; i < 9; i++) run(tbl[i].s, tbl[i].len, tbl[i].rep, tbl[i].abort, tbl[i].lat, tbl[i].nw);
        for (int k = 0; k < 26; k++) begin
            bit s;
            s = k >= 4;
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
            len  = s ? (($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, 8191)) : $urandom_range(0, 40);
            base = s ? 8190 : 0;
            eff  = len < 8192 - base ? len : 8192 - base;
            run(s, 13'(len), 0, 0, 1 + (s ? 8 : 1024) + (eff > 0 ? 1 + eff : 0), eff);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
